// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped branch target buffer with 2-bit saturating
// counters. It gives fetch a zero-latency taken/target prediction. It takes
// resolved branches and jumps from EX, trains the table, and raises a
// same-cycle mispredict redirect.
//
// Optional feature macro: BRPRED_STATS_EN
//   defined   -> 32-bit wrapping counters of resolutions and redirects
//   undefined -> stat_branches / stat_mispredicts are tied to zero, no flops
//
// ENTRIES must be a power of two >= 2, and PC_W - 2 - log2(ENTRIES) must be >= 1
// so that at least one tag bit remains. PC_W is assumed to be <= 32.

module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,

    // Prediction side (fetch)
    input  logic [PC_W-1:0] f_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,

    // Resolution side (EX)
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [31:0]     ex_target,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic            redirect,
    output logic [31:0]     redirect_pc,

    // Statistics
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [ENTRIES-1:0] jmp_q;

    // ------------------------------------------------------------------
    // Address split
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;

    assign f_idx  = f_pc[IDX_W+1:2];
    assign f_tag  = f_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

    // Word alignment makes the low PC bits irrelevant.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[1:0], ex_pc[1:0]};

    // ------------------------------------------------------------------
    // Lookup: purely combinational from registered state, no write bypass
    // ------------------------------------------------------------------
    logic f_hit;

    // Fetch-side hit detection and prediction outputs
    always_comb begin
        f_hit       = 1'b0;
        pred_taken  = 1'b0;
        pred_target = 32'd0;
        if (!reset) begin
            f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
            if (f_hit) begin
                pred_taken  = jmp_q[f_idx] || ctr_q[f_idx][1];
                pred_target = target_q[f_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Resolution and mispredict detection
    // ------------------------------------------------------------------
    logic res_active;
    logic eff_taken;
    logic ex_hit;

    // Decide whether EX resolves a control transfer and whether the carried prediction was wrong
    always_comb begin
        // Gated by reset so that the redirect outputs drop immediately on reset
        res_active  = !reset && ex_valid && (ex_is_branch || ex_is_jump);
        eff_taken   = ex_is_jump || (ex_is_branch && ex_taken);
        ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (res_active) begin
            redirect = (eff_taken != ex_pred_taken) ||
                       (eff_taken && (ex_target != ex_pred_target));
            // Fall-through uses 32-bit arithmetic, so it may carry past PC_W
            redirect_pc = eff_taken ? ex_target : (32'(ex_pc) + 32'd4);
        end
    end

    // ------------------------------------------------------------------
    // Table write data
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [TAG_W-1:0] wr_tag;
    logic [31:0]      wr_target;
    logic [1:0]       wr_ctr;
    logic             wr_jmp;

    // Compute the next contents of the entry addressed by ex_pc
    always_comb begin
        wr_en     = 1'b0;
        wr_tag    = ex_tag;
        wr_target = target_q[ex_idx];
        wr_ctr    = ctr_q[ex_idx];
        wr_jmp    = jmp_q[ex_idx];
        if (res_active) begin
            if (ex_hit) begin
                wr_en  = 1'b1;
                wr_jmp = ex_is_jump;
                if (eff_taken) begin
                    wr_target = ex_target;
                    if (ctr_q[ex_idx] != 2'b11) begin
                        wr_ctr = ctr_q[ex_idx] + 2'd1;
                    end
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    wr_ctr = ctr_q[ex_idx] - 2'd1;
                end
            end else if (eff_taken) begin
                // Allocate, evicting whatever aliased into this slot
                wr_en     = 1'b1;
                wr_target = ex_target;
                wr_ctr    = 2'b10;
                wr_jmp    = ex_is_jump;
            end
        end
    end

    // Table state: asynchronous clear to invalid / weakly-not-taken, single write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= wr_tag;
            target_q[ex_idx] <= wr_target;
            ctr_q[ex_idx]    <= wr_ctr;
            jmp_q[ex_idx]    <= wr_jmp;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BRPRED_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    // Count active resolutions and redirects; both wrap naturally at 32 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branches_q    <= 32'd0;
            mispredicts_q <= 32'd0;
        end else begin
            if (res_active) begin
                branches_q <= branches_q + 32'd1;
            end
            if (redirect) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors with hand-computed expectations for
// branch_predict_unit at PC_W=9, ENTRIES=16 (idx = pc[5:2], tag = pc[8:6]).

module tb_branch_predict_unit;

`ifdef BRPRED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [8:0]  f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks   = 0;
    int failures = 0;

    branch_predict_unit #(
        .PC_W    (9),
        .ENTRIES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .f_pc             (f_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_ex();
        ex_valid       = 1'b0;
        ex_pc          = '0;
        ex_is_branch   = 1'b0;
        ex_is_jump     = 1'b0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    // Present one EX instruction for one cycle, checking the combinational redirect.
    task automatic resolve(input string tag, input logic [8:0] pc, input logic br,
                           input logic jmp, input logic tkn, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt,
                           input logic exp_redir, input logic [31:0] exp_rpc);
        @(negedge clk);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_is_branch   = br;
        ex_is_jump     = jmp;
        ex_taken       = tkn;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        #1;
        check_val({tag, ".redirect"}, 32'(redirect), 32'(exp_redir));
        check_val({tag, ".redirect_pc"}, redirect_pc, exp_rpc);
        @(posedge clk);
        #1;
        clear_ex();
    endtask

    task automatic lookup(input string tag, input logic [8:0] pc, input logic exp_pt,
                          input logic [31:0] exp_tgt);
        @(negedge clk);
        f_pc = pc;
        #1;
        check_val({tag, ".pred_taken"}, 32'(pred_taken), 32'(exp_pt));
        check_val({tag, ".pred_target"}, pred_target, exp_tgt);
    endtask

    task automatic check_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
        check_val({tag, ".stat_branches"}, stat_branches, STATS ? br : 32'd0);
        check_val({tag, ".stat_mispredicts"}, stat_mispredicts, STATS ? mp : 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        f_pc  = 9'h040;
        clear_ex();
        #1;
        check_val("rst.pred_taken", 32'(pred_taken), 32'd0);
        check_val("rst.pred_target", pred_target, 32'd0);
        check_val("rst.redirect", 32'(redirect), 32'd0);
        check_val("rst.redirect_pc", redirect_pc, 32'd0);
        check_stats("rst", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // First taken branch: miss, redirect; same-cycle lookup sees pre-update state
        ex_valid       = 1'b1;
        ex_pc          = 9'h040;
        ex_is_branch   = 1'b1;
        ex_taken       = 1'b1;
        ex_target      = 32'h080;
        #1;
        check_val("b1.redirect", 32'(redirect), 32'd1);
        check_val("b1.redirect_pc", redirect_pc, 32'h080);
        check_val("b1.nobypass", 32'(pred_taken), 32'd0);
        @(posedge clk);
        #1;
        clear_ex();
        lookup("b1.lk", 9'h040, 1'b1, 32'h080);

        // Not-taken twice: ctr 2->1 (redirect to fall-through), then 1->0 (no redirect)
        resolve("nt1", 9'h040, 1, 0, 0, 32'h080, 1, 32'h080, 1'b1, 32'h044);
        lookup("nt1.lk", 9'h040, 1'b0, 32'h080);
        resolve("nt2", 9'h040, 1, 0, 0, 32'h080, 0, 32'h0, 1'b0, 32'h044);
        check_stats("s32", 32'd3, 32'd2);
        // Saturation at 0: one taken gives ctr 1 (still not-taken), a second gives 2
        resolve("nt3", 9'h040, 1, 0, 0, 32'h080, 0, 32'h0, 1'b0, 32'h044);
        resolve("tk1", 9'h040, 1, 0, 1, 32'h080, 0, 32'h0, 1'b1, 32'h080);
        lookup("sat.lk", 9'h040, 1'b0, 32'h080);
        resolve("tk2", 9'h040, 1, 0, 1, 32'h080, 0, 32'h0, 1'b1, 32'h080);
        lookup("tk2.lk", 9'h040, 1'b1, 32'h080);

        // JALR at 0x010 with changing target; ex_taken is ignored for jumps
        resolve("j1", 9'h010, 0, 1, 0, 32'h100, 0, 32'h0, 1'b1, 32'h100);
        lookup("j1.lk", 9'h010, 1'b1, 32'h100);
        resolve("j2", 9'h010, 0, 1, 0, 32'h120, 1, 32'h100, 1'b1, 32'h120);
        lookup("j2.lk", 9'h010, 1'b1, 32'h120);
        resolve("j3", 9'h010, 0, 1, 0, 32'h120, 1, 32'h120, 1'b0, 32'h120);

        // Valid non-control instruction: no redirect, no table update
        resolve("nb", 9'h040, 0, 0, 1, 32'h300, 0, 32'h0, 1'b0, 32'h0);
        lookup("nb.lk", 9'h040, 1'b1, 32'h080);

        // Alias: 0x080 shares idx 0 with 0x040 and evicts it
        resolve("al", 9'h080, 1, 0, 1, 32'h0c0, 0, 32'h0, 1'b1, 32'h0c0);
        lookup("al.old", 9'h040, 1'b0, 32'h0);
        lookup("al.new", 9'h080, 1'b1, 32'h0c0);

        // Not-taken miss at the top of the PC space: no write, fall-through carries past PC_W
        resolve("top", 9'h1fc, 1, 0, 0, 32'h0, 0, 32'h0, 1'b0, 32'h200);
        lookup("top.lk", 9'h1fc, 1'b0, 32'h0);
        check_stats("s117", 32'd11, 32'd7);

        // Reset mid-run, away from a clock edge, with an active mispredicting resolution
        lookup("pre.lk", 9'h010, 1'b1, 32'h120);
        #2;
        ex_valid     = 1'b1;
        ex_pc        = 9'h040;
        ex_is_branch = 1'b1;
        ex_taken     = 1'b1;
        ex_target    = 32'h300;
        reset        = 1'b1;
        #1;
        check_val("mr.pred_taken", 32'(pred_taken), 32'd0);
        check_val("mr.pred_target", pred_target, 32'd0);
        check_val("mr.redirect", 32'(redirect), 32'd0);
        check_val("mr.redirect_pc", redirect_pc, 32'd0);
        check_stats("mr", 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_ex();
        lookup("post.jmp", 9'h010, 1'b0, 32'h0);
        lookup("post.br", 9'h040, 1'b0, 32'h0);
        check_stats("post", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
